// File: rtl/whitening_pkg.sv
// Shared definitions for the whitening-matrix applier and related fixed-point blocks.
// Contents: element/accumulator widths, the applier FSM state type, and sat_shift,
// which scales an accumulator back to element width with clamping.
package whitening_pkg;

   localparam int DW        = 26;
   localparam int COEF_FRAC = 23;
   localparam int ACC_W     = 2*DW+2;

   typedef enum logic [1:0] {
      S_NOCOEF = 2'd0,
      S_IDLE   = 2'd1,
      S_MAC    = 2'd2,
      S_OUT    = 2'd3
   } wa_state_t;

   // Element range expressed at accumulator width, and at element width
   localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
   localparam logic signed [DW-1:0]    Z_HI   = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0]    Z_LO   = {1'b1, {(DW-1){1'b0}}};

   // Arithmetic right shift by COEF_FRAC (rounds toward minus infinity), then clamp
   function automatic logic signed [DW-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] sh;
      logic signed [DW-1:0]    res;
      sh = acc >>> COEF_FRAC;
      if (sh > SAT_HI) begin
         res = Z_HI;
      end else if (sh < SAT_LO) begin
         res = Z_LO;
      end else begin
         res = sh[DW-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/wa_row_mac.sv
// One row of the whitening product: signed DW x DW multiplier feeding an ACC_W
// accumulator.
// Ports: CLK_WA/RSTn_WA clock and async active-low reset; clr_s zeroes the
// accumulator; en_s adds coef_s*samp_s; acc_nxt_s is the accumulator value
// including the current product, so the owner can capture the final sum on the
// same edge as the last MAC.
module wa_row_mac
   import whitening_pkg::*;
(
   input  logic                    CLK_WA,
   input  logic                    RSTn_WA,
   input  logic                    clr_s,
   input  logic                    en_s,
   input  logic signed [DW-1:0]    coef_s,
   input  logic signed [DW-1:0]    samp_s,
   output logic signed [ACC_W-1:0] acc_nxt_s
);

   logic signed [2*DW-1:0]  prod_s;
   logic signed [ACC_W-1:0] acc_r;

   assign prod_s    = coef_s * samp_s;
   assign acc_nxt_s = acc_r + {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};

   // Accumulator: clear on new sample, accumulate one column per enabled cycle
   always_ff @(posedge CLK_WA or negedge RSTn_WA) begin
      if (!RSTn_WA) begin
         acc_r <= '0;
      end else if (clr_s) begin
         acc_r <= '0;
      end else if (en_s) begin
         acc_r <= acc_nxt_s;
      end else begin
         acc_r <= acc_r;
      end
   end

endmodule

// File: rtl/whitening_applier.sv
// Applies a loaded 4x4 whitening matrix V to streamed 4-element vectors: z = V*x.
// Four row MACs process one column per cycle (4 MAC cycles per vector).
// Ports:
//   CLK_WA, RSTn_WA        clock, asynchronous active-low reset
//   Ld_V_WA, V_in_WA       one-cycle load strobe and row-major V (V11 at LSBs)
//   Coef_ok_WA             a V has been loaded since reset
//   X_valid/X_ready/X_in   sample vector handshake (x1 at LSBs)
//   Z_valid/Z_ready/Z_out  result handshake, Z_out registered (z1 at LSBs)
module whitening_applier
   import whitening_pkg::*;
(
   input  logic            CLK_WA,
   input  logic            RSTn_WA,
   input  logic            Ld_V_WA,
   input  logic [16*DW-1:0] V_in_WA,
   output logic            Coef_ok_WA,
   input  logic            X_valid_WA,
   output logic            X_ready_WA,
   input  logic [4*DW-1:0] X_in_WA,
   output logic            Z_valid_WA,
   input  logic            Z_ready_WA,
   output logic [4*DW-1:0] Z_out_WA
);

   wa_state_t state_r;
   wa_state_t state_nxt_s;

   logic [1:0]        cnt_r;
   logic [16*DW-1:0]  v_r;
   logic [4*DW-1:0]   x_r;
   logic              coef_ok_r;
   logic              z_valid_r;
   logic [4*DW-1:0]   z_out_r;

   logic x_ready_s;
   logic load_v_s;
   logic accept_s;
   logic mac_en_s;
   logic done_s;
   logic z_take_s;

   logic signed [DW-1:0]    col_x_s;
   logic signed [DW-1:0]    coef_s    [4];
   logic signed [ACC_W-1:0] acc_nxt_s [4];

   // State register
   always_ff @(posedge CLK_WA or negedge RSTn_WA) begin
      if (!RSTn_WA) begin
         state_r <= S_NOCOEF;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; a V load in S_IDLE wins over a simultaneous sample
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_NOCOEF: begin
            if (Ld_V_WA) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_NOCOEF;
            end
         end
         S_IDLE: begin
            if (!Ld_V_WA && X_valid_WA) begin
               state_nxt_s = S_MAC;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_MAC: begin
            if (cnt_r == 2'd3) begin
               state_nxt_s = S_OUT;
            end else begin
               state_nxt_s = S_MAC;
            end
         end
         S_OUT: begin
            if (Z_ready_WA) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_OUT;
            end
         end
         default: state_nxt_s = S_NOCOEF;
      endcase
   end

   // Per-state control strobes; Ld_V outside S_NOCOEF/S_IDLE is ignored
   always_comb begin
      x_ready_s = 1'b0;
      load_v_s  = 1'b0;
      accept_s  = 1'b0;
      mac_en_s  = 1'b0;
      done_s    = 1'b0;
      z_take_s  = 1'b0;
      case (state_r)
         S_NOCOEF: begin
            load_v_s = Ld_V_WA;
         end
         S_IDLE: begin
            load_v_s  = Ld_V_WA;
            x_ready_s = !Ld_V_WA;
            accept_s  = X_valid_WA && !Ld_V_WA;
         end
         S_MAC: begin
            mac_en_s = 1'b1;
            done_s   = (cnt_r == 2'd3);
         end
         S_OUT: begin
            z_take_s = Z_ready_WA;
         end
         default: begin
            x_ready_s = 1'b0;
         end
      endcase
   end

   // Column select: element cnt of x and column cnt of every row of V
   assign col_x_s = x_r[int'(cnt_r)*DW +: DW];

   for (genvar g = 0; g < 4; g++) begin : g_row
      assign coef_s[g] = v_r[(4*g + int'(cnt_r))*DW +: DW];

      wa_row_mac u_row_mac (
         .CLK_WA    (CLK_WA),
         .RSTn_WA   (RSTn_WA),
         .clr_s     (accept_s),
         .en_s      (mac_en_s),
         .coef_s    (coef_s[g]),
         .samp_s    (col_x_s),
         .acc_nxt_s (acc_nxt_s[g])
      );
   end

   // Coefficient and sample capture, column counter, coefficient-valid flag
   always_ff @(posedge CLK_WA or negedge RSTn_WA) begin
      if (!RSTn_WA) begin
         v_r       <= '0;
         x_r       <= '0;
         cnt_r     <= 2'd0;
         coef_ok_r <= 1'b0;
      end else begin
         if (load_v_s) begin
            v_r       <= V_in_WA;
            coef_ok_r <= 1'b1;
         end else begin
            v_r       <= v_r;
            coef_ok_r <= coef_ok_r;
         end
         if (accept_s) begin
            x_r   <= X_in_WA;
            cnt_r <= 2'd0;
         end else if (mac_en_s) begin
            x_r   <= x_r;
            cnt_r <= cnt_r + 2'd1;
         end else begin
            x_r   <= x_r;
            cnt_r <= cnt_r;
         end
      end
   end

   // Result register: captured with the final MAC (acc_nxt includes column 4)
   always_ff @(posedge CLK_WA or negedge RSTn_WA) begin
      if (!RSTn_WA) begin
         z_valid_r <= 1'b0;
         z_out_r   <= '0;
      end else if (done_s) begin
         z_valid_r <= 1'b1;
         z_out_r   <= {sat_shift(acc_nxt_s[3]), sat_shift(acc_nxt_s[2]),
                       sat_shift(acc_nxt_s[1]), sat_shift(acc_nxt_s[0])};
      end else if (z_take_s) begin
         z_valid_r <= 1'b0;
         z_out_r   <= z_out_r;
      end else begin
         z_valid_r <= z_valid_r;
         z_out_r   <= z_out_r;
      end
   end

   assign Coef_ok_WA = coef_ok_r;
   assign X_ready_WA = x_ready_s;
   assign Z_valid_WA = z_valid_r;
   assign Z_out_WA   = z_out_r;

endmodule

// File: tb/tb_whitening_applier.sv
// Directed self-checking bench for whitening_applier.
module tb_whitening_applier;
   import whitening_pkg::*;

   logic             clk;
   logic             rst_n;
   logic             ld_v;
   logic [16*DW-1:0] v_in;
   logic             coef_ok;
   logic             x_valid;
   logic             x_ready;
   logic [4*DW-1:0]  x_in;
   logic             z_valid;
   logic             z_ready;
   logic [4*DW-1:0]  z_out;

   int n_total = 0;
   int n_fail  = 0;

   whitening_applier dut (
      .CLK_WA     (clk),
      .RSTn_WA    (rst_n),
      .Ld_V_WA    (ld_v),
      .V_in_WA    (v_in),
      .Coef_ok_WA (coef_ok),
      .X_valid_WA (x_valid),
      .X_ready_WA (x_ready),
      .X_in_WA    (x_in),
      .Z_valid_WA (z_valid),
      .Z_ready_WA (z_ready),
      .Z_out_WA   (z_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [4*DW-1:0] obs, input logic [4*DW-1:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4*DW-1:0] vec4(input int a, input int b, input int c, input int d);
      return {DW'(d), DW'(c), DW'(b), DW'(a)};
   endfunction

   function automatic logic [16*DW-1:0] diag(input int d);
      logic [16*DW-1:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[(5*i)*DW +: DW] = DW'(d);
      return r;
   endfunction

   function automatic logic [16*DW-1:0] row1(input int d);
      logic [16*DW-1:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) r[c*DW +: DW] = DW'(d);
      return r;
   endfunction

   // Pulse Ld_V for one cycle while idle; ready must drop during the pulse
   task automatic load_v(input logic [16*DW-1:0] v);
      v_in = v;
      ld_v = 1'b1;
      #1;
      chk("ready_low_during_load", x_ready, 1'b0);
      tick();
      ld_v = 1'b0;
      #1;
      chk("coef_ok_after_load", coef_ok, 1'b1);
   endtask

   // Present a vector, wait for acceptance, then check 4-edge latency to Z_valid
   task automatic send(input logic [4*DW-1:0] x);
      int w;
      int lat;
      x_in    = x;
      x_valid = 1'b1;
      #1;
      w = 0;
      while (!x_ready && w < 20) begin
         tick();
         w++;
      end
      chk("accept_timeout", x_ready, 1'b1);
      tick();
      x_valid = 1'b0;
      chk("ready_low_in_mac", x_ready, 1'b0);
      lat = 0;
      while (!z_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("latency", lat, 4);
   endtask

   initial begin
      int cyc;
      int n_acc;
      int acc_cyc [4];
      int w;

      rst_n   = 1'b0;
      ld_v    = 1'b0;
      v_in    = '0;
      x_valid = 1'b0;
      x_in    = '0;
      z_ready = 1'b1;
      tick();
      tick();
      chk("rst_coef_ok", coef_ok, 1'b0);
      chk("rst_x_ready", x_ready, 1'b0);
      chk("rst_z_valid", z_valid, 1'b0);
      chk("rst_z_out", z_out, '0);
      rst_n = 1'b1;

      // No coefficients: samples must be refused
      x_in    = vec4(100, -200, 300, -400);
      x_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("nocoef_x_ready", x_ready, 1'b0);
         chk("nocoef_z_valid", z_valid, 1'b0);
      end
      x_valid = 1'b0;

      // Identity (1.0 = 2^23)
      load_v(diag(8388608));
      chk("idle_ready", x_ready, 1'b1);
      send(vec4(100, -200, 300, -400));
      chk("identity_z", z_out, vec4(100, -200, 300, -400));
      tick();
      chk("identity_z_valid_drop", z_valid, 1'b0);
      chk("identity_z_held", z_out, vec4(100, -200, 300, -400));
      chk("identity_ready_back", x_ready, 1'b1);

      // Saturation high and low on row 1
      load_v(row1(33554431));
      send(vec4(33554431, 33554431, 33554431, 33554431));
      chk("sat_hi_z", z_out, vec4(33554431, 0, 0, 0));
      tick();
      load_v(row1(-33554431));
      send(vec4(33554431, 33554431, 33554431, 33554431));
      chk("sat_lo_z", z_out, vec4(-33554432, 0, 0, 0));
      tick();

      // Truncation toward minus infinity with V = 0.5*I
      load_v(diag(4194304));
      send(vec4(-3, 3, -1, 1));
      chk("trunc_z", z_out, vec4(-2, 1, -1, 0));
      tick();

      // Back-pressure: hold result for 5 cycles
      z_ready = 1'b0;
      send(vec4(10, 20, 30, 40));
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_z_valid", z_valid, 1'b1);
         chk("bp_z_out", z_out, vec4(5, 10, 15, 20));
         chk("bp_x_ready", x_ready, 1'b0);
      end
      z_ready = 1'b1;
      tick();
      chk("bp_release_z_valid", z_valid, 1'b0);
      chk("bp_release_x_ready", x_ready, 1'b1);

      // Back-to-back throughput with Z_ready held high
      x_in    = vec4(10, 20, 30, 40);
      x_valid = 1'b1;
      #1;
      n_acc = 0;
      for (cyc = 0; cyc < 20; cyc++) begin
         if (x_ready && n_acc < 4) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
         end
         tick();
      end
      x_valid = 1'b0;
      chk("b2b_accept_count", n_acc, 4);
      chk("b2b_interval_1", acc_cyc[1] - acc_cyc[0], 6);
      chk("b2b_interval_2", acc_cyc[2] - acc_cyc[1], 6);
      chk("b2b_interval_3", acc_cyc[3] - acc_cyc[2], 6);
      w = 0;
      while (!z_valid && w < 20) begin
         tick();
         w++;
      end
      chk("b2b_z_valid", z_valid, 1'b1);
      chk("b2b_z", z_out, vec4(5, 10, 15, 20));
      tick();

      // Ld_V collides with X_valid in idle: load wins, sample taken next cycle
      x_in    = vec4(1, 2, 3, 4);
      x_valid = 1'b1;
      v_in    = diag(16777216);
      ld_v    = 1'b1;
      #1;
      chk("collide_ready_low", x_ready, 1'b0);
      tick();
      ld_v = 1'b0;
      #1;
      chk("collide_still_idle", x_ready, 1'b1);
      send(vec4(1, 2, 3, 4));
      chk("collide_new_v", z_out, vec4(2, 4, 6, 8));
      tick();

      // Ld_V during MAC is ignored
      x_in    = vec4(1, 1, 1, 1);
      x_valid = 1'b1;
      #1;
      chk("macld_ready", x_ready, 1'b1);
      tick();
      x_valid = 1'b0;
      v_in    = diag(8388608);
      ld_v    = 1'b1;
      tick();
      ld_v = 1'b0;
      tick();
      tick();
      tick();
      chk("macld_z_valid", z_valid, 1'b1);
      chk("macld_old_v", z_out, vec4(2, 2, 2, 2));
      tick();
      send(vec4(1, 1, 1, 1));
      chk("macld_v_kept", z_out, vec4(2, 2, 2, 2));
      tick();

      // Asynchronous reset while cnt=2
      x_in    = vec4(1, 1, 1, 1);
      x_valid = 1'b1;
      #1;
      tick();
      x_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("arst_z_out", z_out, '0);
      chk("arst_z_valid", z_valid, 1'b0);
      chk("arst_coef_ok", coef_ok, 1'b0);
      chk("arst_x_ready", x_ready, 1'b0);
      tick();
      rst_n   = 1'b1;
      x_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post_rst_x_ready", x_ready, 1'b0);
         chk("post_rst_z_valid", z_valid, 1'b0);
      end
      x_valid = 1'b0;
      load_v(diag(8388608));
      send(vec4(7, -7, 0, 5));
      chk("post_rst_z", z_out, vec4(7, -7, 0, 5));
      tick();

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule

// File: doc/whitening_applier.md
Name: whitening_applier

Overview:
- Consumes the 4x4 whitening matrix V produced by the whitening multiplier and applies it to streamed 4-element sample vectors: z = V·x.
- Sits between sample centering and the FastICA iteration core.
- Time-multiplexed: four row multipliers, one column per cycle.
- Coefficient load and sample/result transfer both use handshakes.

Parameters:
- DW, 26, signed width of the sample, coefficient and result elements.
- COEF_FRAC, 23, number of fraction bits in V; the product is shifted right by this amount.
- ACC_W, 2*DW+2, signed accumulator width per row.

Ports:
- CLK_WA  in  1  clock.
- RSTn_WA  in  1  reset. One clock; reset is asynchronous and active-low.
- Ld_V_WA  in  1  one-cycle pulse; captures V_in_WA.
- V_in_WA  in  16*DW  V flattened row-major, V11 at bits [DW-1:0], V44 at the top.
- Coef_ok_WA  out  1  high once a V has been loaded since reset.
- X_valid_WA  in  1  sample vector valid.
- X_ready_WA  out  1  block can accept a sample vector.
- X_in_WA  in  4*DW  x1 at the LSBs.
- Z_valid_WA  out  1  result valid.
- Z_ready_WA  in  1  downstream accepts the result.
- Z_out_WA  out  4*DW  z1 at the LSBs; registered.

Behaviour:
- Reset values:
  - All outputs 0.
  - State S_NOCOEF, counter 0.
  - Accumulators, V register and x register all 0.
- FSM states:
  - S_NOCOEF: X_ready=0. Ld_V moves to S_IDLE and sets Coef_ok.
  - S_IDLE: X_ready = !Ld_V.
    - Ld_V reloads V and stays in S_IDLE; a load takes priority over a simultaneous X_valid.
    - X_valid && X_ready captures x, clears the accumulators, sets cnt=0 and moves to S_MAC.
  - S_MAC: each cycle, for i=1..4, acc_i += V[i][cnt+1]*x[cnt+1] as a full-precision signed product, sign-extended to ACC_W.
    - cnt increments each cycle.
    - When cnt==3, register Z and move to S_OUT.
  - S_OUT: Z_valid=1.
    - Z_out is held stable until Z_ready is seen.
    - Z_ready moves to S_IDLE and clears Z_valid. Z_out keeps its last value.
- Ld_V in S_MAC or S_OUT is ignored. V never changes mid-vector.
- Latency and throughput:
  - Sample accepted at edge k.
  - MACs occur at edges k+1..k+4.
  - Z_valid rises at edge k+4.
  - With Z_ready tied high, one vector is accepted every 6 cycles.
- Output arithmetic:
  - z_i = sat_DW(acc_i >>> COEF_FRAC).
  - The shift is arithmetic, so truncation is toward minus infinity.
  - Saturation clamps to [-2^(DW-1), 2^(DW-1)-1].
- X_ready=0 in S_NOCOEF, S_MAC and S_OUT.
- Asynchronous reset mid-operation:
  - Aborts the vector.
  - Clears Coef_ok; V must be reloaded.
  - No Z_valid is produced for the aborted vector.
- X_valid while X_ready=0: the input is not captured, and the upstream must hold it.

Decomposition:
- Shared package (whitening_pkg) holds:
  - DW, COEF_FRAC, ACC_W;
  - the state enum (S_NOCOEF, S_IDLE, S_MAC, S_OUT);
  - a sat_shift function (arithmetic shift then clamp) shared with other fixed-point blocks.
- One sub-module, wa_row_mac:
  - one signed DW x DW multiplier plus an ACC_W accumulator with clear/enable;
  - instantiated four times.
- FSM, column mux and output register live in the top module.

Test Plan:
- Identity, no load: after reset, X_valid=1 for 10 cycles -> X_ready stays 0, Z_valid stays 0. Then load V = diag(8388608) and send x=(100,-200,300,-400) -> Z_valid after 4 further edges with z=(100,-200,300,-400).
- Saturation: V row1 all 33554431, x all 33554431 -> z1 = 33554431. Row1 negated -> z1 = -33554432.
- Truncation: V = diag(4194304), x=(-3,3,-1,1) -> z=(-2,1,-1,0).
- Back-pressure: hold Z_ready=0 for 5 cycles after Z_valid -> Z_out stable, X_ready=0 throughout. On Z_ready=1, next cycle X_ready=1. Back-to-back vectors with Z_ready=1 -> one accept every 6 cycles.
- Load collisions:
  - Ld_V together with X_valid in S_IDLE -> V updated, sample not accepted; the next cycle accepts it using the new V.
  - Ld_V pulse during S_MAC -> ignored, result uses the old V.
- Reset: assert RSTn_WA=0 during S_MAC (cnt=2) -> all outputs 0 immediately, Coef_ok=0. After release, X_ready=0 until a new Ld_V.
